// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done handshake and operand/result bundle for seq_divider
interface seq_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [1:0] divisor;
    logic [7:0] quotient;
    logic [1:0] remainder;
    logic       busy;
    logic       done;
    logic       div_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 8-bit by 2-bit sequential restoring divider, one quotient bit per clock
module seq_divider (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [2:0] count;
    // After each step the partial remainder is below the divisor, so two bits
    // hold it between cycles; only the shifted trial value needs three bits.
    logic [1:0] pr;
    logic [7:0] qsr;
    logic [7:0] dvd_reg;
    logic [1:0] dvs_reg;

    logic [7:0] q_out;
    logic [1:0] r_out;
    logic       dz;

    logic [2:0] t;
    logic       qbit;
    logic [1:0] pr_nxt;
    logic [7:0] qsr_nxt;

    logic       accept;
    logic       accept_zero;
    logic       busy_c;
    logic       done_c;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        t       = {pr, dvd_reg[count]};
        qbit    = (t >= {1'b0, dvs_reg});
        pr_nxt  = qbit ? 2'(t - {1'b0, dvs_reg}) : t[1:0];
        qsr_nxt = {qsr[6:0], qbit};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; start only matters in IDLE.
    always_comb begin
        state_nxt   = state;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        accept      = 1'b0;
        accept_zero = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != 2'b00) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        accept_zero = 1'b1;
                        state_nxt   = DONE;
                    end
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (count == 3'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, iteration, and result registers that only move when entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 3'd0;
            pr      <= 2'd0;
            qsr     <= 8'd0;
            dvd_reg <= 8'd0;
            dvs_reg <= 2'd0;
            q_out   <= 8'd0;
            r_out   <= 2'd0;
            dz      <= 1'b0;
        end else if (accept) begin
            dvd_reg <= bus.dividend;
            dvs_reg <= bus.divisor;
            pr      <= 2'd0;
            qsr     <= 8'd0;
            count   <= 3'd7;
            dz      <= 1'b0;
        end else if (accept_zero) begin
            q_out <= 8'hFF;
            r_out <= 2'd0;
            dz    <= 1'b1;
        end else if (state == RUN) begin
            pr  <= pr_nxt;
            qsr <= qsr_nxt;
            if (count == 3'd0) begin
                q_out <= qsr_nxt;
                r_out <= pr_nxt;
            end else begin
                count <= count - 3'd1;
            end
        end
    end

    assign bus.quotient  = q_out;
    assign bus.remainder = r_out;
    assign bus.div_zero  = dz;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;

endmodule
